// File: rtl/bsg_dmc_ui_arbiter.sv
// bsg_dmc_ui_arbiter
//   Shares one DMC user interface between num_req_p requesters. An idle
//   arbiter grants one requester round-robin, issues its command to the
//   DMC, then streams the owner's write beats. Read returns are steered
//   back to their issuer through a small FIFO of requester tags.
// Ports
//   clk_i, reset_i           : ui clock, synchronous active-high reset
//   init_calib_complete_i    : DMC ready; no new grant while low
//   req_*                    : per-requester command (valid/we/addr) and
//                              single-cycle one-hot accept (req_yumi_o)
//   wdata_* / wmask_i        : per-requester write beats, wdata_yumi_o
//                              pulses when the owner's beat is taken
//   rdata_*                  : read return, valid routed to the owner
//   app_*                    : DMC command / write-data / read-data ports

// Run-time checks on the arbiter's internal invariants.
module bsg_dmc_ui_arbiter_chk #(
  parameter int num_req_p = 2
) (
  input logic                 clk_i,
  input logic                 reset_i,
  input logic                 rd_valid_i,
  input logic                 tag_empty_i,
  input logic [num_req_p-1:0] req_yumi_i,
  input logic [num_req_p-1:0] wdata_yumi_i
);
  // read data with no outstanding tag has no owner to go to
  rd_without_tag: assert property (@(posedge clk_i) disable iff (reset_i)
    !(rd_valid_i && tag_empty_i));
  yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(req_yumi_i));
  wdata_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(wdata_yumi_i));
endmodule

module bsg_dmc_ui_arbiter #(
  parameter int num_req_p         = 2,
  parameter int ui_addr_width_p   = 28,
  parameter int ui_data_width_p   = 32,
  parameter int ui_burst_length_p = 8,
  parameter int rd_tag_els_p      = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     init_calib_complete_i,
  input  logic [num_req_p-1:0]                     req_v_i,
  input  logic [num_req_p-1:0]                     req_we_i,
  input  logic [num_req_p*ui_addr_width_p-1:0]     req_addr_i,
  output logic [num_req_p-1:0]                     req_yumi_o,
  input  logic [num_req_p-1:0]                     wdata_v_i,
  input  logic [num_req_p*ui_data_width_p-1:0]     wdata_i,
  input  logic [num_req_p*(ui_data_width_p/8)-1:0] wmask_i,
  output logic [num_req_p-1:0]                     wdata_yumi_o,
  output logic [num_req_p-1:0]                     rdata_v_o,
  output logic [ui_data_width_p-1:0]               rdata_o,
  output logic                                     rdata_last_o,
  output logic                                     app_en_o,
  output logic [2:0]                               app_cmd_o,
  output logic [ui_addr_width_p-1:0]               app_addr_o,
  input  logic                                     app_rdy_i,
  output logic                                     app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]               app_wdf_data_o,
  output logic [ui_data_width_p/8-1:0]             app_wdf_mask_o,
  output logic                                     app_wdf_end_o,
  input  logic                                     app_wdf_rdy_i,
  input  logic                                     app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]               app_rd_data_i,
  input  logic                                     app_rd_data_end_i
);
  localparam int mask_w_lp = ui_data_width_p / 8;
  localparam int idx_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int beat_w_lp = (ui_burst_length_p > 1) ? $clog2(ui_burst_length_p) : 1;
  localparam int ptr_w_lp  = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1;
  localparam int cnt_w_lp  = $clog2(rd_tag_els_p + 1);
  localparam logic [idx_w_lp:0]    num_req_lp   = (idx_w_lp + 1)'(num_req_p);
  localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(ui_burst_length_p - 1);
  localparam logic [ptr_w_lp-1:0]  last_ptr_lp  = ptr_w_lp'(rd_tag_els_p - 1);
  localparam logic [cnt_w_lp-1:0]  full_cnt_lp  = cnt_w_lp'(rd_tag_els_p);

  typedef enum logic [1:0] {
    e_idle  = 2'b00,
    e_cmd   = 2'b01,
    e_wdata = 2'b10
  } state_e;

  state_e                     state_q, state_d;
  logic [ui_addr_width_p-1:0] addr_q, addr_d;
  logic                       we_q, we_d;
  logic [idx_w_lp-1:0]        owner_q, owner_d;
  logic [idx_w_lp-1:0]        rr_q, rr_d;
  logic [beat_w_lp-1:0]       beat_q, beat_d;
  logic [ptr_w_lp-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic [idx_w_lp-1:0]        tag_mem_q [rd_tag_els_p];

  logic                       grant_v_s;
  logic [idx_w_lp-1:0]        grant_idx_s;
  logic [idx_w_lp:0]          cand_s, next_rr_s;
  logic                       owner_wdata_v_s;
  logic                       tag_push_s, tag_pop_s, tag_empty_s, tag_full_s;
  logic [idx_w_lp-1:0]        tag_head_s;

  assign tag_empty_s = (cnt_q == '0);
  assign tag_full_s  = (cnt_q == full_cnt_lp);
  assign tag_head_s  = tag_mem_q[rptr_q];
  assign app_addr_o  = addr_q;
  assign app_cmd_o   = we_q ? 3'b000 : 3'b001;

  // Round-robin search starting at rr_q; reads wait while every tag is in use
  always_comb begin
    grant_v_s   = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand_s = {1'b0, rr_q} + (idx_w_lp + 1)'(i);
      if (cand_s >= num_req_lp) begin
        cand_s = cand_s - num_req_lp;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_v_s && req_v_i[cand_s[idx_w_lp-1:0]]
          && (req_we_i[cand_s[idx_w_lp-1:0]] || !tag_full_s)) begin
        grant_v_s   = 1'b1;
        grant_idx_s = cand_s[idx_w_lp-1:0];
      end else begin
        grant_v_s   = grant_v_s;
      end
    end
    next_rr_s = {1'b0, grant_idx_s} + (idx_w_lp + 1)'(1);
    if (next_rr_s >= num_req_lp) begin
      next_rr_s = '0;
    end else begin
      next_rr_s = next_rr_s;
    end
  end

  // Write-data mux from the current owner
  always_comb begin
    owner_wdata_v_s = 1'b0;
    app_wdf_data_o  = '0;
    app_wdf_mask_o  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (owner_q == idx_w_lp'(i)) begin
        owner_wdata_v_s = wdata_v_i[i];
        app_wdf_data_o  = wdata_i[i*ui_data_width_p +: ui_data_width_p];
        app_wdf_mask_o  = wmask_i[i*mask_w_lp +: mask_w_lp];
      end else begin
        owner_wdata_v_s = owner_wdata_v_s;
      end
    end
  end

  // Arbiter FSM: next state, latched command and handshake outputs
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    beat_d         = beat_q;
    req_yumi_o     = '0;
    wdata_yumi_o   = '0;
    app_en_o       = 1'b0;
    app_wdf_wren_o = 1'b0;
    app_wdf_end_o  = 1'b0;
    tag_push_s     = 1'b0;
    case (state_q)
      e_idle: begin
        // the reset_i term keeps yumi quiet during the reset cycle itself
        if (init_calib_complete_i && grant_v_s && !reset_i) begin
          req_yumi_o[grant_idx_s] = 1'b1;
          addr_d  = req_addr_i[grant_idx_s*ui_addr_width_p +: ui_addr_width_p];
          we_d    = req_we_i[grant_idx_s];
          owner_d = grant_idx_s;
          rr_d    = next_rr_s[idx_w_lp-1:0];
          state_d = e_cmd;
        end else begin
          state_d = e_idle;
        end
      end
      e_cmd: begin
        app_en_o = 1'b1;
        if (app_rdy_i) begin
          if (we_q) begin
            state_d = e_wdata;
          end else begin
            tag_push_s = 1'b1;
            state_d    = e_idle;
          end
        end else begin
          state_d = e_cmd;
        end
      end
      e_wdata: begin
        app_wdf_wren_o = owner_wdata_v_s;
        app_wdf_end_o  = (beat_q == last_beat_lp);
        if (owner_wdata_v_s && app_wdf_rdy_i) begin
          wdata_yumi_o[owner_q] = 1'b1;
          if (beat_q == last_beat_lp) begin
            beat_d  = '0;
            state_d = e_idle;
          end else begin
            beat_d  = beat_q + beat_w_lp'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  // Read return: route valid to the head tag's owner, pop on the last beat
  always_comb begin
    rdata_o      = app_rd_data_i;
    rdata_last_o = app_rd_data_end_i;
    tag_pop_s    = app_rd_data_valid_i && app_rd_data_end_i && !tag_empty_s;
    for (int i = 0; i < num_req_p; i++) begin
      rdata_v_o[i] = app_rd_data_valid_i && !tag_empty_s && (tag_head_s == idx_w_lp'(i));
    end
  end

  // Tag FIFO pointer and occupancy update
  always_comb begin
    if (tag_push_s) begin
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (tag_pop_s) begin
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({tag_push_s, tag_pop_s})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk_i) begin
    if (tag_push_s) begin
      tag_mem_q[wptr_q] <= owner_q;
    end
  end

  bsg_dmc_ui_arbiter_chk #(.num_req_p(num_req_p)) chk (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rd_valid_i   (app_rd_data_valid_i),
    .tag_empty_i  (tag_empty_s),
    .req_yumi_i   (req_yumi_o),
    .wdata_yumi_i (wdata_yumi_o)
  );
endmodule

// File: doc/bsg_dmc_ui_arbiter.md
BSG_DMC_UI_ARBITER -- requirements
Module: bsg_dmc_ui_arbiter

Interface
REQ-001 Parameter num_req_p, default 2: number of requesters sharing the DMC user interface.
REQ-002 Parameter ui_addr_width_p, default 28: app address width.
REQ-003 Parameter ui_data_width_p, default 32: app write/read data width; mask width is ui_data_width_p/8.
REQ-004 Parameter ui_burst_length_p, default 8: data beats per command.
REQ-005 Parameter rd_tag_els_p, default 4: maximum outstanding reads.
REQ-006 The block SHALL use one clock, clk_i (ui_clk), and a synchronous active-high reset, reset_i.
REQ-007 Ports SHALL be:
- clk_i  in  1  ui clock
- reset_i  in  1  sync reset, active high
- init_calib_complete_i  in  1  DMC ready for traffic
- req_v_i  in  N  command valid per requester
- req_we_i  in  N  1=write, 0=read
- req_addr_i  in  N*addr  command address
- req_yumi_o  out  N  command accepted (one-hot, single cycle)
- wdata_v_i  in  N  write beat valid
- wdata_i  in  N*dw  write beat data
- wmask_i  in  N*dw/8  write beat mask
- wdata_yumi_o  out  N  write beat consumed
- rdata_v_o  out  N  read beat valid, routed to owner
- rdata_o  out  dw  read beat data (shared)
- rdata_last_o  out  1  last beat of a read burst
- app_en_o, app_cmd_o[2:0], app_addr_o  out  command to DMC
- app_rdy_i  in  1  DMC accepts command
- app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o  out  write data to DMC
- app_wdf_rdy_i  in  1  DMC accepts write beat
- app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i  in  read return from DMC

Function
REQ-008 FSM states SHALL be IDLE, CMD, WDATA.
REQ-009 In IDLE with init_calib_complete_i=1, the block SHALL grant one requester with req_v_i set, round-robin starting after the last granted index. Reads are eligible only when the tag FIFO is not full.
REQ-010 On grant, the block SHALL register the requester's addr, we and index, and pulse req_yumi_o for that requester in the same cycle. The next state is CMD.
REQ-011 In CMD, app_en_o=1, app_addr_o=latched addr, app_cmd_o=3'b000 for write or 3'b001 for read.
REQ-012 Command handshake: the command transfers on app_en_o & app_rdy_i. The block SHALL hold all app command outputs stable until the transfer.
REQ-013 After a read transfers, the block SHALL push the requester index into the tag FIFO and return to IDLE.
REQ-014 After a write transfers, the block SHALL move to WDATA.
REQ-015 In WDATA:
- app_wdf_wren_o = wdata_v_i[owner].
- data and mask are muxed from the owner.
- a beat transfers on wren & app_wdf_rdy_i; wdata_yumi_o[owner] pulses in the same cycle.
- a beat counter (width clog2(ui_burst_length_p)) increments per transfer.
- app_wdf_end_o=1 on beat ui_burst_length_p-1.
- after the last transfer the counter wraps to 0 and the state returns to IDLE.
REQ-016 The block SHALL NOT assert wdata_yumi_o outside WDATA, nor for a non-owner.
REQ-017 Read return:
- rdata_v_o[tag FIFO head] = app_rd_data_valid_i.
- rdata_o = app_rd_data_i.
- rdata_last_o = app_rd_data_end_i.
- the FIFO pops when app_rd_data_valid_i & app_rd_data_end_i.
- latency is zero cycles (combinational routing).
REQ-018 A tag push and pop in the same cycle SHALL leave the occupancy unchanged. A push while full cannot occur (REQ-009).
REQ-019 read data valid while the FIFO is empty is an error: the block SHALL drive rdata_v_o=0 and, in simulation, raise an assertion.
REQ-020 With init_calib_complete_i=0, no new grant SHALL occur. An in-flight CMD or WDATA SHALL complete.
REQ-021 app_ref_req, app_zq_req and app_sr_req are not driven by this block.

Reset
REQ-022 While reset_i=1, at the next edge: state=IDLE, beat counter=0, tag FIFO empty, round-robin pointer=0 (requester 0 has highest priority first).
REQ-023 Reset outputs SHALL be: app_en_o=0, app_wdf_wren_o=0, app_wdf_end_o=0, req_yumi_o=0, wdata_yumi_o=0, rdata_v_o=0. Data and address outputs are don't-care.
REQ-024 A reset in mid-burst SHALL abandon the burst; no partial-state recovery is required.

Verification
REQ-025 Req0 and req1 issue writes simultaneously, calib=1, rdy=1 -> req0 is granted first with 8 wren beats and wdf_end on beat 7, then req1. Total: 2 commands and 16 beats.
REQ-026 app_rdy_i is held 0 for 5 cycles in CMD -> app_en_o stays 1 with address and cmd stable, and exactly one command transfers.
REQ-027 app_wdf_rdy_i toggles 1,0,1,0 during WDATA -> exactly 8 transfers, with the data order preserved and end aligned to the 8th transfer.
REQ-028 Reads from req1 then req0, with 8 return beats each -> the first 8 beats go to rdata_v_o[1] and the next 8 to rdata_v_o[0], with rdata_last_o on beats 8 and 16.
REQ-029 Issue 4 reads with no return -> a 5th read is not granted, while a write from the other requester is still granted. The 5th read is granted after the first burst returns.
REQ-030 Assert reset_i in WDATA at beat 3 -> the next cycle has all outputs at reset values, and calib=0 blocks any grant afterward.
